// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// Gray/binary helpers are width-generic: zero-extend in, truncate out.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_width(input int address_size);
        return address_size + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g
    );
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Generic N-bit two-flop synchroniser, asynchronous active-high reset.
// Only safe for buses where at most one bit changes per source cycle.
module fifo_sync_2ff #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller of the dual-clock FIFO.
// Optional write_almost_full output: define FIFO_WRITE_ALMOST_FULL_EN.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int address_size       = 4,
    parameter int almost_full_margin = 2
) (
    input  logic                    write_clk,
    input  logic                    write_reset,
    input  logic                    write_inc,
    input  logic [address_size:0]   read_ptr_gray,
    output logic                    write_en,
    output logic                    write_full,
    output logic [address_size-1:0] write_address,
    output logic [address_size:0]   write_ptr_gray,
    output logic [address_size:0]   write_level,
    output logic                    write_overflow
`ifdef FIFO_WRITE_ALMOST_FULL_EN
    ,
    output logic                    write_almost_full
`endif
);

    localparam int PW    = ptr_width(address_size);
    localparam int DEPTH = 1 << address_size;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          accept;

    fifo_sync_2ff #(
        .width(PW)
    ) u_rsync (
        .clk (write_clk),
        .rst (write_reset),
        .d   (read_ptr_gray),
        .q   (rq2)
    );

    assign accept     = write_inc & ~write_full;
    assign write_en   = accept;
    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign rbin       = PW'(gray2bin(32'(rq2)));
    assign level_next = wbin_next - rbin;

    // Full when writer is one lap ahead: top two Gray bits inverted.
    assign full_next = (wgray_next ==
                        {~rq2[PW-1:PW-2], rq2[PW-3:0]});

    assign write_address = wbin[address_size-1:0];

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            wbin           <= '0;
            write_ptr_gray <= '0;
            write_full     <= 1'b0;
            write_level    <= '0;
            write_overflow <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            write_ptr_gray <= wgray_next;
            write_full     <= full_next;
            write_level    <= level_next;
            write_overflow <= write_overflow
                            | (write_inc & write_full);
        end
    end

`ifdef FIFO_WRITE_ALMOST_FULL_EN
    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            write_almost_full <= 1'b0;
        end else begin
            write_almost_full <= (level_next >=
                PW'(DEPTH - almost_full_margin));
        end
    end
`endif

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Write-side pointer and flag controller for the dual-clock FIFO. It sits directly upstream of the FIFO memory, entirely in the write clock domain. It accepts producer write requests and drives the memory's write enable, write address and full flag. It also synchronises the read domain's Gray-coded pointer and publishes its own Gray pointer back to the read side.

## Interface

Parameters:
- address_size, 4, memory address width; depth = 2**address_size
- almost_full_margin, 2, free-slot threshold for write_almost_full (only used with the macro)

Ports:
- write_clk  in  1  write-domain clock; all state updates on rising edge
- write_reset  in  1  reset, asynchronous, active-high
- write_inc  in  1  producer write request, one entry per cycle while high
- read_ptr_gray  in  address_size+1  read pointer, Gray-coded, from read domain (asynchronous to write_clk)
- write_en  out  1  memory write strobe = write_inc & !write_full (combinational)
- write_full  out  1  FIFO full, registered
- write_address  out  address_size  memory write address, registered
- write_ptr_gray  out  address_size+1  write pointer, Gray-coded, registered, to read domain
- write_level  out  address_size+1  entries occupied as seen from write domain, registered
- write_overflow  out  1  sticky: a request arrived while full
- write_almost_full  out  1  registered; present only with FIFO_WRITE_ALMOST_FULL_EN

## Operation

- Internal binary pointer wbin, width address_size+1; write_address = wbin[address_size-1:0].
- Accept = write_inc & !write_full. On an accept, wbin_next = wbin + 1, modulo 2**(address_size+1); otherwise wbin_next = wbin.
- write_ptr_gray <= wbin_next ^ (wbin_next >> 1).
- read_ptr_gray passes through a 2-flop synchroniser to produce rq2.
- write_full <= (gray(wbin_next) == {~rq2[top:top-1], rq2[top-2:0]}).
- write_level <= wbin_next - bin(rq2), modulo 2**(address_size+1). Range is 0..depth.
- write_overflow <= 1 when write_inc & write_full. It clears only on reset.
- Reset values: wbin=0, write_address=0, write_ptr_gray=0, synchroniser flops=0, write_full=0, write_level=0, write_overflow=0, write_almost_full=0.
- Reset asserted mid-operation clears all state immediately. The memory contents are not touched.
- Full boundary: a request while write_full=1 is rejected, write_en=0, and the pointer holds.
- Wrap-around: wbin wraps from 2**(address_size+1)-1 to 0. write_address wraps every depth accepts.
- Simultaneous request at full and incoming read-pointer advance: the request is rejected that cycle, because full is a registered decision. It is accepted only once write_full has deasserted.

## Timing

- A write accepted at edge N is captured by the memory at edge N. write_address and write_ptr_gray show the next slot after edge N.
- Full assertion is immediate: write_full rises at the same edge as the accept that fills the last slot.
- Read-pointer latency: a change on read_ptr_gray before edge N appears in rq2 after edge N+1. write_full and write_level reflect it after edge N+2.
- Deassertion of full is therefore pessimistic by 3 cycles, which is safe.

## Configuration

- FIFO_WRITE_ALMOST_FULL_EN defined:
  - write_almost_full <= (level_next >= depth - almost_full_margin).
  - level_next is the same value registered into write_level.
- Not defined: the port, its register and the almost_full_margin comparison are absent.

## Structure

- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised on width
  - the pointer width convention: address_size+1
- Sub-module fifo_sync_2ff is the generic N-bit two-flop synchroniser with asynchronous active-high reset. It is reused by the read-side controller.

## Test plan

- Reset: hold write_reset with write_inc=1 -> all outputs 0, write_en=1 (not full).
- Fill, with read_ptr_gray=0 and 16 accepted writes -> write_full=1 after the 16th edge, write_address=0, write_ptr_gray=5'b11000, write_level=16.
- Overflow: at full, write_inc=1 -> write_en=0, address held at 0, write_overflow=1 and remains 1 after write_inc drops.
- Drain visibility: from full, set read_ptr_gray=5'b00110 (bin 4) -> write_full=0 and write_level=12 after exactly 3 edges.
- Wrap: 32 total writes with the reader tracking -> write_ptr_gray returns through 5'b10000 to 0, and write_address cycles 0..15 twice with no false full.
- Almost full (macro on, margin 2): 14 writes with read_ptr_gray=0 -> write_almost_full=1 and write_level=14. After 13 writes it is 0.
